// File: rtl/price_window_stats_pkg.sv
// Shared types and width helpers for the price_window_stats block.
// State encoding is exported so the top and any checker agree on it.
package price_window_stats_pkg;

  typedef enum logic [2:0] {
    WARM  = 3'd0,
    IDLE  = 3'd1,
    STORE = 3'd2,
    SORT  = 3'd3,
    ADD   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Bits needed to index a DEPTH-entry window (DEPTH is a power of two).
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

  // Accumulator width: DEPTH samples of DATA_W bits can never overflow this.
  function automatic int sum_width(input int data_w, input int depth);
    return data_w + $clog2(depth);
  endfunction

endpackage

// File: rtl/price_window_stats_sort_pass.sv
// One odd-even transposition pass over the sort array.
// odd=0 compares pairs (0,1),(2,3)...; odd=1 compares (1,2),(3,4)...
// Each pair leaves ordered ascending (unsigned). Purely combinational.
module price_window_stats_sort_pass #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] din,
  input  logic                         odd,
  output logic [DEPTH-1:0][DATA_W-1:0] dout
);

  // Compare-exchange every pair selected by odd.
  always_comb begin
    dout = din;
    if (!odd) begin
      for (int p = 0; p < DEPTH / 2; p++) begin
        if (din[2*p] > din[2*p+1]) begin
          dout[2*p]   = din[2*p+1];
          dout[2*p+1] = din[2*p];
        end
      end
    end else begin
      for (int p = 0; p < DEPTH / 2 - 1; p++) begin
        if (din[2*p+1] > din[2*p+2]) begin
          dout[2*p+1] = din[2*p+2];
          dout[2*p+2] = din[2*p+1];
        end
      end
    end
  end

endmodule

// File: rtl/price_window_stats.sv
// Sliding-window min/max/median/mean over the latest DEPTH stock prices.
// Optional feature macro: PRICE_SORT_EN. When defined, a DEPTH-cycle
// odd-even sort runs before accumulation and median_price is valid.
// When undefined, STORE goes straight to ADD and median_price reads 0.
// Sample strobe: a sample is taken on any rising edge where data_ready=1
// and the engine is not busy; a strobe while busy is dropped and sets the
// sticky overrun flag. There is no back-pressure toward the source.
module price_window_stats
  import price_window_stats_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] stock_price,
  input  logic              data_ready,
  output logic              busy,
  output logic              window_full,
  output logic              stats_valid,
  output logic [DATA_W-1:0] min_price,
  output logic [DATA_W-1:0] max_price,
  output logic [DATA_W-1:0] median_price,
  output logic [DATA_W-1:0] avg_price,
  output logic              overrun,
  output state_t            dbg_state
);

  localparam int IDX_W  = idx_width(DEPTH);
  localparam int SUM_W  = sum_width(DATA_W, DEPTH);
  localparam int FILL_W = IDX_W + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);

  state_t                      state;
  logic [DEPTH-1:0][DATA_W-1:0] win;
  logic [DEPTH-1:0][DATA_W-1:0] arr;
  logic [IDX_W-1:0]            wr_ptr;
  logic [IDX_W-1:0]            cnt;
  logic [FILL_W-1:0]           fill;
  logic [SUM_W-1:0]            sum;
  logic [DATA_W-1:0]           run_min;
  logic [DATA_W-1:0]           run_max;

  logic                        accept;
  logic [DATA_W-1:0]           elem;
  logic [SUM_W-1:0]            add_sum;
  logic [DATA_W-1:0]           add_min;
  logic [DATA_W-1:0]           add_max;
  logic [DATA_W-1:0]           median_next;

  assign dbg_state = state;
  assign accept    = data_ready && (state == WARM || state == IDLE);

  // Scan step: fold the current element into the running statistics.
  assign elem    = arr[cnt];
  assign add_sum = sum + SUM_W'(elem);
  assign add_min = (elem < run_min) ? elem : run_min;
  assign add_max = (elem > run_max) ? elem : run_max;

`ifdef PRICE_SORT_EN
  logic [DEPTH-1:0][DATA_W-1:0] sorted_next;

  price_window_stats_sort_pass #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_sort_pass (
    .din  (arr),
    .odd  (cnt[0]),
    .dout (sorted_next)
  );

  // Upper median of the sorted window.
  assign median_next = arr[DEPTH/2];
`else
  assign median_next = '0;
`endif

  // Circular sample window; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      win[wr_ptr] <= stock_price;
    end
  end

  // Control FSM plus the sort/accumulate datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WARM;
      busy         <= 1'b0;
      window_full  <= 1'b0;
      stats_valid  <= 1'b0;
      min_price    <= '0;
      max_price    <= '0;
      median_price <= '0;
      avg_price    <= '0;
      overrun      <= 1'b0;
      wr_ptr       <= '0;
      fill         <= '0;
      cnt          <= '0;
      sum          <= '0;
      run_min      <= '0;
      run_max      <= '0;
    end else begin
      stats_valid <= 1'b0;
      if (data_ready && !accept) begin
        overrun <= 1'b1;
      end
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case (state)
        WARM: begin
          if (data_ready) begin
            fill <= fill + 1'b1;
            if (fill == FILL_LAST) begin
              window_full <= 1'b1;
              busy        <= 1'b1;
              state       <= STORE;
            end
          end
        end
        IDLE: begin
          if (data_ready) begin
            busy  <= 1'b1;
            state <= STORE;
          end
        end
        STORE: begin
          arr     <= win;
          cnt     <= '0;
          sum     <= '0;
          run_min <= '1;
          run_max <= '0;
`ifdef PRICE_SORT_EN
          state   <= SORT;
`else
          state   <= ADD;
`endif
        end
        SORT: begin
`ifdef PRICE_SORT_EN
          arr <= sorted_next;
`endif
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state <= ADD;
          end
        end
        ADD: begin
          sum     <= add_sum;
          run_min <= add_min;
          run_max <= add_max;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            min_price    <= add_min;
            max_price    <= add_max;
            avg_price    <= DATA_W'(add_sum >> IDX_W);
            median_price <= median_next;
            stats_valid  <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= WARM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_price_window_stats.sv
// Directed bench for price_window_stats at DEPTH=4, DATA_W=32.
// Expected values are hand-computed; latency and median follow PRICE_SORT_EN.
module tb_price_window_stats;
  import price_window_stats_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
`ifdef PRICE_SORT_EN
  localparam int LAT = 2 * DEPTH + 2;
`else
  localparam int LAT = DEPTH + 2;
`endif

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] stock_price;
  logic              data_ready;
  logic              busy;
  logic              window_full;
  logic              stats_valid;
  logic [DATA_W-1:0] min_price;
  logic [DATA_W-1:0] max_price;
  logic [DATA_W-1:0] median_price;
  logic [DATA_W-1:0] avg_price;
  logic              overrun;
  state_t            dbg_state;

  int vectors;
  int miscompares;

  price_window_stats #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stock_price  (stock_price),
    .data_ready   (data_ready),
    .busy         (busy),
    .window_full  (window_full),
    .stats_valid  (stats_valid),
    .min_price    (min_price),
    .max_price    (max_price),
    .median_price (median_price),
    .avg_price    (avg_price),
    .overrun      (overrun),
    .dbg_state    (dbg_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Median is only meaningful when the sort stage is built.
  function automatic logic [31:0] exp_med(input logic [31:0] v);
`ifdef PRICE_SORT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  // Present one sample for one cycle.
  task automatic send(input logic [DATA_W-1:0] v);
    stock_price = v;
    data_ready  = 1'b1;
    tick();
    data_ready  = 1'b0;
  endtask

  // Count cycles until stats_valid, bounded; n starts at the caller's cycle index.
  task automatic wait_valid(input int start, output int n);
    n = start;
    while (stats_valid !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_stats(input string tag, input logic [31:0] mn, input logic [31:0] mx,
                           input logic [31:0] md, input logic [31:0] av);
    chk({tag, "_valid"}, 32'(stats_valid), 32'd1);
    chk({tag, "_min"}, min_price, mn);
    chk({tag, "_max"}, max_price, mx);
    chk({tag, "_median"}, median_price, md);
    chk({tag, "_avg"}, avg_price, av);
  endtask

  initial begin
    int n;
    logic seen;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    data_ready  = 1'b0;
    stock_price = '0;

    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(window_full), 32'd0);
    chk("rst_valid", 32'(stats_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_min", min_price, 32'd0);
    chk("rst_max", max_price, 32'd0);
    chk("rst_median", median_price, 32'd0);
    chk("rst_avg", avg_price, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(WARM));

    // First window: 10,40,20,30.
    send(32'd10);
    send(32'd40);
    send(32'd20);
    chk("warm_full", 32'(window_full), 32'd0);
    chk("warm_busy", 32'(busy), 32'd0);
    send(32'd30);
    chk("w1_busy", 32'(busy), 32'd1);
    chk("w1_full", 32'(window_full), 32'd1);
    wait_valid(1, n);
    chk("w1_latency", 32'(n), 32'(LAT));
    chk_stats("w1", 32'd10, 32'd40, exp_med(32'd30), 32'd25);
    chk("w1_busy_done", 32'(busy), 32'd1);
    tick();
    chk("w1_valid_pulse", 32'(stats_valid), 32'd0);
    chk("w1_busy_low", 32'(busy), 32'd0);
    chk("w1_hold_min", min_price, 32'd10);
    chk("w1_state_idle", 32'(dbg_state), 32'(IDLE));

    // Slide in 50 and drop 99 while busy: window {50,40,20,30}.
    send(32'd50);
    tick();
    stock_price = 32'd99;
    data_ready  = 1'b1;
    tick();
    data_ready  = 1'b0;
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_busy", 32'(busy), 32'd1);
    wait_valid(3, n);
    chk("w2_latency", 32'(n), 32'(LAT));
    chk_stats("w2", 32'd20, 32'd50, exp_med(32'd40), 32'd35);
    tick();
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // 60 overwrites 40, proving 99 never entered: window {50,60,20,30}.
    send(32'd60);
    wait_valid(1, n);
    chk("w3_latency", 32'(n), 32'(LAT));
    chk_stats("w3", 32'd20, 32'd60, exp_med(32'd50), 32'd40);
    chk("w3_overrun", 32'(overrun), 32'd1);
    tick();

    // Reset while in ADD: everything clears and no result follows.
    send(32'd70);
    for (int i = 1; i < LAT - 2; i++) tick();
    chk("mid_state_add", 32'(dbg_state), 32'(ADD));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_full", 32'(window_full), 32'd0);
    chk("mid_rst_valid", 32'(stats_valid), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("mid_rst_min", min_price, 32'd0);
    chk("mid_rst_avg", avg_price, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 2 * LAT; i++) begin
      tick();
      seen = seen | stats_valid;
    end
    chk("mid_rst_no_valid", 32'(seen), 32'd0);

    // All-ones window: sum needs the extra bits, average stays all ones.
    send(32'hFFFF_FFFF);
    send(32'hFFFF_FFFF);
    send(32'hFFFF_FFFF);
    seen = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      tick();
      seen = seen | stats_valid | window_full;
    end
    chk("ff_three_no_result", 32'(seen), 32'd0);
    send(32'hFFFF_FFFF);
    wait_valid(1, n);
    chk("ff_latency", 32'(n), 32'(LAT));
    chk_stats("ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, exp_med(32'hFFFF_FFFF), 32'hFFFF_FFFF);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
